// File: rtl/driver_mon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | driver_mon_pkg                                                         |
// | Shared types and constants for driver monitor statistics readout.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package driver_mon_pkg;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_HDR   = 3'd1,
    RD_DATA  = 3'd2,
    RD_STAT  = 3'd3,
    RD_TRAIL = 3'd4
  } rd_state_t;

  localparam logic [1:0] HIST_ADDR_GAP  = 2'd0;
  localparam logic [1:0] HIST_ADDR_FILL = 2'd1;
  localparam logic [1:0] HIST_VCTR_GAP  = 2'd2;
  localparam logic [1:0] HIST_VCTR_FILL = 2'd3;

  localparam logic [15:0] MARKER_DEFAULT = 16'hD3A5;

  // Words per frame: header, 4 histograms, FIFO-count word, trailer.
  function automatic int unsigned frame_len(input int unsigned num_bins);
    return 4 * num_bins + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/driver_monitor_readout.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | driver_monitor_readout                                                 |
// | Snapshots monitor histograms and streams them as one AXI-S frame.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module driver_monitor_readout
  import driver_mon_pkg::*;
#(
  parameter int          NUM_BINS = 16,
  parameter int          CNT_W    = 16,
  parameter logic [15:0] MARKER   = MARKER_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_BINS*CNT_W-1:0] addr_mon_cnts_flat,
  input  logic [NUM_BINS*CNT_W-1:0] addr_fifo_mon_cnts_flat,
  input  logic [NUM_BINS*CNT_W-1:0] vctr_mon_cnts_flat,
  input  logic [NUM_BINS*CNT_W-1:0] vctr_fifo_mon_cnts_flat,
  input  logic [15:0]               words_in_addr_fifo,
  input  logic [15:0]               words_in_vctr_fifo,
  output logic [31:0]               m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      req_dropped,
  output logic [7:0]                seq_num
);

  localparam int              BIN_W       = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [BIN_W-1:0] c_last_bin = BIN_W'(NUM_BINS - 1);
  localparam logic [7:0]       c_nbins_enc = 8'(NUM_BINS);

  rd_state_t        r_state, w_state_next;
  logic [1:0]       r_hist, w_nxt_hist;
  logic [BIN_W-1:0] r_bin, w_nxt_bin;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [31:0]      w_data_word;
  logic [31:0]      r_checksum;
  logic [15:0]      r_words_a, r_words_v;
  logic             w_xfer, w_last_data, w_launch;

  logic [CNT_W-1:0] r_snap_ag [NUM_BINS];
  logic [CNT_W-1:0] r_snap_af [NUM_BINS];
  logic [CNT_W-1:0] r_snap_vg [NUM_BINS];
  logic [CNT_W-1:0] r_snap_vf [NUM_BINS];

  assign w_xfer      = m_tvalid && m_tready;
  assign w_launch    = (r_state == RD_IDLE) && start;
  assign w_last_data = (r_hist == 2'd3) && (r_bin == c_last_bin);
  assign busy        = (r_state != RD_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= RD_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RD_IDLE:  if (start)                 w_state_next = RD_HDR;
      RD_HDR:   if (w_xfer)                w_state_next = RD_DATA;
      RD_DATA:  if (w_xfer && w_last_data) w_state_next = RD_STAT;
      RD_STAT:  if (w_xfer)                w_state_next = RD_TRAIL;
      RD_TRAIL: if (w_xfer)                w_state_next = RD_IDLE;
      default:                             w_state_next = RD_IDLE;
    endcase
  end

  // Index of the data word to load on the current handshake.
  always_comb begin
    w_nxt_hist = r_hist;
    w_nxt_bin  = r_bin + 1'b1;
    if (r_state == RD_HDR) begin
      w_nxt_hist = 2'd0;
      w_nxt_bin  = '0;
    end else if (r_bin == c_last_bin) begin
      w_nxt_hist = r_hist + 2'd1;
      w_nxt_bin  = '0;
    end
  end

  always_comb begin
    w_nxt_cnt = '0;
    case (w_nxt_hist)
      HIST_ADDR_GAP:  w_nxt_cnt = r_snap_ag[w_nxt_bin];
      HIST_ADDR_FILL: w_nxt_cnt = r_snap_af[w_nxt_bin];
      HIST_VCTR_GAP:  w_nxt_cnt = r_snap_vg[w_nxt_bin];
      HIST_VCTR_FILL: w_nxt_cnt = r_snap_vf[w_nxt_bin];
      default:        w_nxt_cnt = '0;
    endcase
  end

  assign w_data_word = {2'b00, w_nxt_hist, 4'h0, 8'(w_nxt_bin), 16'(w_nxt_cnt)};

  always_ff @(posedge clk) begin
    if (w_launch) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        r_snap_ag[i] <= addr_mon_cnts_flat[i*CNT_W +: CNT_W];
        r_snap_af[i] <= addr_fifo_mon_cnts_flat[i*CNT_W +: CNT_W];
        r_snap_vg[i] <= vctr_mon_cnts_flat[i*CNT_W +: CNT_W];
        r_snap_vf[i] <= vctr_fifo_mon_cnts_flat[i*CNT_W +: CNT_W];
      end
      r_words_a <= words_in_addr_fifo;
      r_words_v <= words_in_vctr_fifo;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      frame_done  <= 1'b0;
      req_dropped <= 1'b0;
      seq_num     <= '0;
      r_checksum  <= '0;
      r_hist      <= '0;
      r_bin       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (start && (r_state != RD_IDLE)) req_dropped <= 1'b1;
      case (r_state)
        RD_IDLE: begin
          if (start) begin
            req_dropped <= 1'b0;
            r_checksum  <= '0;
            m_tvalid    <= 1'b1;
            m_tlast     <= 1'b0;
            m_tdata     <= {MARKER, seq_num, c_nbins_enc};
          end
        end
        RD_HDR, RD_DATA: begin
          if (w_xfer) begin
            r_checksum <= r_checksum ^ m_tdata;
            if ((r_state == RD_DATA) && w_last_data) begin
              m_tdata <= {r_words_a, r_words_v};
            end else begin
              m_tdata <= w_data_word;
              r_hist  <= w_nxt_hist;
              r_bin   <= w_nxt_bin;
            end
          end
        end
        RD_STAT: begin
          // Trailer folds the outgoing stat word into the running XOR.
          if (w_xfer) begin
            r_checksum <= r_checksum ^ m_tdata;
            m_tdata    <= r_checksum ^ m_tdata;
            m_tlast    <= 1'b1;
          end
        end
        RD_TRAIL: begin
          if (w_xfer) begin
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            seq_num    <= seq_num + 8'd1;
            frame_done <= 1'b1;
          end
        end
        default: m_tvalid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
